// File: rtl/npu_vec_engine.sv
// npu_vec_engine: multi-lane dot-product engine with a built-in read sequencer.
// A shared feature vector and LANES weight vectors are streamed from synchronous
// memory. Each lane's biased sum is requantised (shift, optional ReLU, saturate)
// and presented on a valid/ready output.
module npu_vec_engine #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         cfg_feat_base,
    input  logic [ADDR_WIDTH-1:0]         cfg_w_base,
    input  logic [ADDR_WIDTH-1:0]         cfg_len,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_relu,
    input  logic [LANES*ACC_WIDTH-1:0]    cfg_bias,
    output logic                          mem_rd_en,
    output logic [ADDR_WIDTH-1:0]         mem_feat_addr,
    output logic [ADDR_WIDTH-1:0]         mem_w_addr,
    input  logic [DATA_WIDTH-1:0]         mem_feat_rdata,
    input  logic [LANES*DATA_WIDTH-1:0]   mem_w_rdata,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [LANES*DATA_WIDTH-1:0]   o_data,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic signed [PROD_WIDTH-1:0] prod_t;

    localparam acc_t SAT_MAX = acc_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam acc_t SAT_MIN = ~SAT_MAX;

    logic [2:0]                   state, state_nxt;
    logic [ADDR_WIDTH-1:0]        cnt, cnt_nxt;
    logic [4:0]                   shift_q, shift_nxt;
    logic                         relu_q, relu_nxt;
    logic                         rd_en_nxt;
    logic [ADDR_WIDTH-1:0]        feat_addr_nxt, w_addr_nxt;
    logic                         rvalid;
    logic                         o_valid_nxt;
    logic [LANES*DATA_WIDTH-1:0]  o_data_nxt;
    logic                         busy_nxt, done_nxt;
    logic                         load_c;
    acc_t                         acc     [LANES];
    acc_t                         acc_nxt [LANES];
    prod_t                        prod    [LANES];

    // Shift, optional ReLU and saturation of one accumulator to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] requant(input acc_t a, input logic [4:0] sh,
                                                      input logic relu);
        acc_t r;
        r = a >>> sh;
        if (relu && r[ACC_WIDTH-1]) r = '0;
        if (r > SAT_MAX)      r = SAT_MAX;
        else if (r < SAT_MIN) r = SAT_MIN;
        return r[DATA_WIDTH-1:0];
    endfunction

    assign load_c = (state == S_IDLE) && start;

    // Per-lane MAC: bias load on job start, accumulate while read data is valid.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            prod[i] = PROD_WIDTH'($signed(mem_feat_rdata))
                    * PROD_WIDTH'($signed(mem_w_rdata[i*DATA_WIDTH +: DATA_WIDTH]));
            if (load_c)      acc_nxt[i] = $signed(cfg_bias[i*ACC_WIDTH +: ACC_WIDTH]);
            else if (rvalid) acc_nxt[i] = acc[i] + ACC_WIDTH'(prod[i]);
            else             acc_nxt[i] = acc[i];
        end
    end

    // Next-state and registered-output logic of the job sequencer.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        shift_nxt     = shift_q;
        relu_nxt      = relu_q;
        rd_en_nxt     = 1'b0;
        feat_addr_nxt = mem_feat_addr;
        w_addr_nxt    = mem_w_addr;
        o_valid_nxt   = o_valid;
        o_data_nxt    = o_data;
        case (state)
            S_IDLE: begin
                if (start) begin
                    shift_nxt     = cfg_shift;
                    relu_nxt      = cfg_relu;
                    feat_addr_nxt = cfg_feat_base;
                    w_addr_nxt    = cfg_w_base;
                    if (cfg_len == '0) begin
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_RUN;
                        rd_en_nxt = 1'b1;
                        cnt_nxt   = cfg_len - ADDR_WIDTH'(1);
                    end
                end
            end
            S_RUN: begin
                if (cnt == '0) begin
                    state_nxt = S_WAIT;
                end else begin
                    rd_en_nxt     = 1'b1;
                    cnt_nxt       = cnt - ADDR_WIDTH'(1);
                    feat_addr_nxt = mem_feat_addr + ADDR_WIDTH'(1);
                    w_addr_nxt    = mem_w_addr + ADDR_WIDTH'(1);
                end
            end
            S_WAIT: begin
                // The last read returns this cycle, so requantise the updated sums.
                state_nxt   = S_OUT;
                o_valid_nxt = 1'b1;
                for (int i = 0; i < int'(LANES); i++) begin
                    o_data_nxt[i*DATA_WIDTH +: DATA_WIDTH] = requant(acc_nxt[i], shift_q, relu_q);
                end
            end
            S_OUT: begin
                if (o_ready) begin
                    o_valid_nxt = 1'b0;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt   = S_IDLE;
                o_valid_nxt = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

    // State, configuration, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            shift_q       <= '0;
            relu_q        <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_feat_addr <= '0;
            mem_w_addr    <= '0;
            rvalid        <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < int'(LANES); i++) acc[i] <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            shift_q       <= shift_nxt;
            relu_q        <= relu_nxt;
            mem_rd_en     <= rd_en_nxt;
            mem_feat_addr <= feat_addr_nxt;
            mem_w_addr    <= w_addr_nxt;
            rvalid        <= mem_rd_en;
            o_valid       <= o_valid_nxt;
            o_data        <= o_data_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            for (int i = 0; i < int'(LANES); i++) acc[i] <= acc_nxt[i];
        end
    end

endmodule

// File: tb/tb_npu_vec_engine.sv
// Directed bench for npu_vec_engine: synchronous memory model, scoreboard queue
// of expected lane results, latency/handshake/reset checks.
module tb_npu_vec_engine;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 20;
    localparam int unsigned ADW   = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic [ADW-1:0]        cfg_feat_base = '0;
    logic [ADW-1:0]        cfg_w_base = '0;
    logic [ADW-1:0]        cfg_len = '0;
    logic [4:0]            cfg_shift = '0;
    logic                  cfg_relu = 1'b0;
    logic [LANES*AW-1:0]   cfg_bias = '0;
    logic                  mem_rd_en;
    logic [ADW-1:0]        mem_feat_addr, mem_w_addr;
    logic [DW-1:0]         mem_feat_rdata = '0;
    logic [LANES*DW-1:0]   mem_w_rdata = '0;
    logic                  o_valid;
    logic                  o_ready = 1'b1;
    logic [LANES*DW-1:0]   o_data;
    logic                  busy, done;

    logic [DW-1:0]         feat_mem [256];
    logic [LANES*DW-1:0]   w_mem    [256];
    logic [ADW-1:0]        faddr_q [$];
    logic [ADW-1:0]        waddr_q [$];
    logic [LANES*DW-1:0]   exp_q   [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    npu_vec_engine #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_feat_base(cfg_feat_base), .cfg_w_base(cfg_w_base), .cfg_len(cfg_len),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_bias(cfg_bias),
        .mem_rd_en(mem_rd_en), .mem_feat_addr(mem_feat_addr), .mem_w_addr(mem_w_addr),
        .mem_feat_rdata(mem_feat_rdata), .mem_w_rdata(mem_w_rdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .busy(busy), .done(done)
    );

    // Synchronous read memory with one-cycle latency; logs read addresses.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_feat_rdata <= feat_mem[mem_feat_addr];
            mem_w_rdata    <= w_mem[mem_w_addr];
            faddr_q.push_back(mem_feat_addr);
            waddr_q.push_back(mem_w_addr);
        end
    end

    function automatic logic [LANES*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [LANES*AW-1:0] bias4(input int a, input int b, input int c, input int d);
        return {AW'(d), AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one job request; returns just after the sampling edge E0.
    task automatic start_job(input logic [ADW-1:0] fb, input logic [ADW-1:0] wb,
                             input logic [ADW-1:0] len, input logic [4:0] sh, input logic relu,
                             input logic [LANES*AW-1:0] bias, input logic [LANES*DW-1:0] expv,
                             input bit push);
        @(negedge clk);
        cfg_feat_base = fb;
        cfg_w_base    = wb;
        cfg_len       = len;
        cfg_shift     = sh;
        cfg_relu      = relu;
        cfg_bias      = bias;
        start         = 1'b1;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start         = 1'b0;
        cfg_feat_base = ADW'($urandom);
        cfg_w_base    = ADW'($urandom);
        cfg_len       = ADW'($urandom);
        cfg_shift     = 5'($urandom);
        cfg_relu      = 1'($urandom);
        cfg_bias      = {$urandom, $urandom, $urandom};
    endtask

    // Wait for the result, check latency, data, backpressure and done pulse.
    task automatic finish_job(input string tag, input int len, input int hold, input bit poke);
        int c = 0;
        int rd = 0;
        int first = -1;
        logic [LANES*DW-1:0] expv;
        logic [LANES*DW-1:0] held;
        expv = '0;
        while (c < 300) begin
            @(negedge clk);
            c++;
            if (poke && c == 2) begin
                start         = 1'b1;
                cfg_len       = 8'd1;
                cfg_feat_base = 8'd200;
                cfg_bias      = '1;
            end else begin
                start = 1'b0;
            end
            if (mem_rd_en) rd++;
            if (o_valid) begin
                first = c;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_valid_cycle"}, 64'(first), 64'(len + 2));
        chk({tag, "_rd_cycles"}, 64'(rd), 64'(len));
        if (exp_q.size() > 0) expv = exp_q.pop_front();
        chk({tag, "_data"}, 64'(o_data), 64'(expv));
        if (first < 0) return;
        held = o_data;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_bp_hold"}, {o_valid, done, o_data}, {1'b1, 1'b0, held});
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {done, o_valid}, {1'b1, 1'b0});
        @(negedge clk);
        chk({tag, "_done_end"}, {done, busy}, {1'b0, 1'b0});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            feat_mem[i] = '0;
            w_mem[i]    = '0;
        end
        feat_mem[0] = 8'd1; feat_mem[1] = 8'd2; feat_mem[2] = 8'd3;
        w_mem[16] = pack4(1, 2, -1, 0);
        w_mem[17] = pack4(1, 0, -1, 0);
        w_mem[18] = pack4(1, 0, -1, 1);
        for (int k = 0; k < 8; k++) begin
            feat_mem[32+k] = 8'd127;
            w_mem[64+k]    = pack4(127, 127, 127, 127);
            w_mem[80+k]    = pack4(-128, -128, -128, -128);
        end
        feat_mem[254] = 8'd5;
        feat_mem[255] = 8'hFD;
        for (int k = 0; k < 4; k++) w_mem[100+k] = pack4(1, k + 1, 1, 1);

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_outputs", {mem_rd_en, mem_feat_addr, mem_w_addr, o_valid, o_data, busy, done}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic job, with a start pulse while busy that must be ignored
        start_job(8'd0, 8'd16, 8'd3, 5'd0, 1'b0, bias4(5, 5, 5, 5), pack4(11, 7, -1, 8), 1'b1);
        finish_job("basic", 3, 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy_start_ignored", {busy, mem_rd_en}, 2'b00);
        end

        // Saturation and requantisation
        start_job(8'd32, 8'd64, 8'd8, 5'd0, 1'b0, bias4(0, 0, 0, 0), pack4(127, 127, 127, 127), 1'b1);
        finish_job("sat_pos", 8, 0, 1'b0);
        start_job(8'd32, 8'd64, 8'd8, 5'd10, 1'b0, bias4(0, 0, 0, 0), pack4(126, 126, 126, 126), 1'b1);
        finish_job("shift10", 8, 0, 1'b0);
        start_job(8'd32, 8'd80, 8'd8, 5'd0, 1'b0, bias4(0, 0, 0, 0), pack4(-128, -128, -128, -128), 1'b1);
        finish_job("sat_neg", 8, 0, 1'b0);

        // ReLU
        start_job(8'd0, 8'd16, 8'd3, 5'd0, 1'b1, bias4(5, 5, 5, 5), pack4(11, 7, 0, 8), 1'b1);
        finish_job("relu", 3, 0, 1'b0);

        // Backpressure
        o_ready = 1'b0;
        start_job(8'd0, 8'd16, 8'd3, 5'd0, 1'b0, bias4(5, 5, 5, 5), pack4(11, 7, -1, 8), 1'b1);
        finish_job("backpressure", 3, 5, 1'b0);

        // Zero-length job: bias only
        start_job(8'd0, 8'd16, 8'd0, 5'd0, 1'b0, bias4(3, -4, 200, -200), pack4(3, -4, 127, -128), 1'b1);
        finish_job("len0", 0, 0, 1'b0);

        // Address wrap
        faddr_q.delete();
        waddr_q.delete();
        start_job(8'd254, 8'd100, 8'd4, 5'd0, 1'b0, bias4(0, 0, 0, 0), pack4(5, 10, 5, 5), 1'b1);
        finish_job("wrap", 4, 0, 1'b0);
        chk("wrap_nreads", 64'(faddr_q.size()), 64'd4);
        if (faddr_q.size() == 4) begin
            chk("wrap_feat_addrs", {faddr_q[3], faddr_q[2], faddr_q[1], faddr_q[0]},
                {8'd1, 8'd0, 8'd255, 8'd254});
            chk("wrap_w_addrs", {waddr_q[3], waddr_q[2], waddr_q[1], waddr_q[0]},
                {8'd103, 8'd102, 8'd101, 8'd100});
        end

        // Reset during RUN aborts the job
        start_job(8'd0, 8'd16, 8'd6, 5'd0, 1'b0, bias4(5, 5, 5, 5), '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_busy", {busy, mem_rd_en}, 2'b11);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {mem_rd_en, mem_feat_addr, mem_w_addr, o_valid, o_data, busy, done}, '0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort_quiet", {o_valid, done, busy}, 3'b000);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_reset_idle", {o_valid, done, busy, mem_rd_en}, 4'b0000);
        end
        start_job(8'd0, 8'd16, 8'd3, 5'd0, 1'b0, bias4(5, 5, 5, 5), pack4(11, 7, -1, 8), 1'b1);
        finish_job("after_reset", 3, 0, 1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
